// File: rtl/multicycle_controller_pkg.sv
// rtl/multicycle_controller_pkg.sv - opcodes, state encoding and datapath select codes
package multicycle_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC_R   = 4'd3,
        ST_WB_R     = 4'd4,
        ST_EXEC_I   = 4'd5,
        ST_WB_I     = 4'd6,
        ST_MEM_ADDR = 4'd7,
        ST_MEM_RD   = 4'd8,
        ST_WB_MEM   = 4'd9,
        ST_MEM_WR   = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_JUMP     = 4'd12,
        ST_FAULT    = 4'd13
    } state_e;

    typedef enum logic [2:0] {
        OPC_R       = 3'd0,
        OPC_LOAD    = 3'd1,
        OPC_STORE   = 3'd2,
        OPC_BRANCH  = 3'd3,
        OPC_JUMP    = 3'd4,
        OPC_IMM     = 3'd5,
        OPC_ILLEGAL = 3'd6
    } opc_class_e;

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - controller <-> datapath control bus
interface multicycle_controller_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       Opcode;
    logic             Zero;
    logic             MemReady;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             MemtoReg;
    logic             RegDst;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic [1:0]       PCSource;
    logic             BranchNe;
    logic [CNT_W-1:0] InstrCount;
    logic             Fault;

    // PC load enable as the datapath sees it: unconditional or taken branch
    logic             w_pc_load;
    assign w_pc_load = PCWrite | (PCWriteCond & (Zero ^ BranchNe));

    modport master (
        input  Opcode, Zero, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, BranchNe, InstrCount, Fault
    );

    modport slave (
        output Opcode, Zero, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, BranchNe, InstrCount, Fault, w_pc_load
    );
endinterface

// File: rtl/multicycle_controller_opcode_class.sv
// rtl/multicycle_controller_opcode_class.sv - opcode to instruction class decode
module mc_opcode_class
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    output opc_class_e o_class
);

    // Pure lookup; anything not listed is illegal and sends the FSM to FAULT
    always_comb begin
        o_class = OPC_ILLEGAL;
        case (i_opcode)
            OP_RTYPE:                         o_class = OPC_R;
            OP_LW:                            o_class = OPC_LOAD;
            OP_SW:                            o_class = OPC_STORE;
            OP_BEQ, OP_BNE:                   o_class = OPC_BRANCH;
            OP_J:                             o_class = OPC_JUMP;
            OP_ADDI, OP_SLTI, OP_ANDI,
            OP_ORI, OP_XORI:                  o_class = OPC_IMM;
            default:                          o_class = OPC_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle MIPS control FSM with retire counter and memory timeout
module multicycle_controller
    import multicycle_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    multicycle_controller_if.master  bus
);

    // Last stall cycle allowed; a stall while the counter sits here faults
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [7:0]       r_wait;
    logic [CNT_W-1:0] r_count;
    logic             r_fault;
    logic             r_is_store;
    logic             r_branch_ne;

    opc_class_e       w_class;
    logic             w_mem_state;
    logic             w_timeout;
    logic             w_retire;

    logic             w_pc_write;
    logic             w_pc_write_cond;
    logic             w_iord;
    logic             w_mem_read;
    logic             w_mem_write;
    logic             w_ir_write;
    logic             w_mem_to_reg;
    logic             w_reg_dst;
    logic             w_reg_write;
    logic             w_alu_src_a;
    logic [1:0]       w_alu_src_b;
    logic [1:0]       w_alu_op;
    logic [1:0]       w_pc_source;

    mc_opcode_class u_opcode_class (
        .i_opcode (bus.Opcode),
        .o_class  (w_class)
    );

    assign w_mem_state = (r_state == ST_FETCH) || (r_state == ST_MEM_RD) ||
                         (r_state == ST_MEM_WR);
    assign w_timeout   = w_mem_state && !bus.MemReady && (r_wait == TIMEOUT_LAST);

    // Next-state and per-state datapath controls; everything defaults to idle
    always_comb begin
        w_state_next    = r_state;
        w_retire        = 1'b0;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_iord          = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_reg_dst       = 1'b0;
        w_reg_write     = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = SRCB_RT;
        w_alu_op        = ALUOP_ADD;
        w_pc_source     = PCSRC_ALU;
        case (r_state)
            ST_IDLE: begin
                w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = SRCB_FOUR;
                if (bus.MemReady) begin
                    w_ir_write   = 1'b1;
                    w_pc_write   = 1'b1;
                    w_state_next = ST_DECODE;
                end else if (w_timeout) begin
                    w_state_next = ST_FAULT;
                end
            end
            ST_DECODE: begin
                w_alu_src_b = SRCB_IMM_SH;
                case (w_class)
                    OPC_R:               w_state_next = ST_EXEC_R;
                    OPC_LOAD, OPC_STORE: w_state_next = ST_MEM_ADDR;
                    OPC_BRANCH:          w_state_next = ST_BRANCH;
                    OPC_JUMP:            w_state_next = ST_JUMP;
                    OPC_IMM:             w_state_next = ST_EXEC_I;
                    default:             w_state_next = ST_FAULT;
                endcase
            end
            ST_EXEC_R: begin
                w_alu_src_a  = 1'b1;
                w_alu_op     = ALUOP_FUNCT;
                w_state_next = ST_WB_R;
            end
            ST_WB_R: begin
                w_reg_dst    = 1'b1;
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
                w_state_next = ST_FETCH;
            end
            ST_EXEC_I: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = SRCB_IMM;
                w_alu_op     = ALUOP_IMM;
                w_state_next = ST_WB_I;
            end
            ST_WB_I: begin
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
                w_state_next = ST_FETCH;
            end
            ST_MEM_ADDR: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = SRCB_IMM;
                w_state_next = r_is_store ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                w_iord     = 1'b1;
                w_mem_read = 1'b1;
                if (bus.MemReady) begin
                    w_state_next = ST_WB_MEM;
                end else if (w_timeout) begin
                    w_state_next = ST_FAULT;
                end
            end
            ST_WB_MEM: begin
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
                w_state_next = ST_FETCH;
            end
            ST_MEM_WR: begin
                w_iord      = 1'b1;
                w_mem_write = 1'b1;
                if (bus.MemReady) begin
                    w_retire     = 1'b1;
                    w_state_next = ST_FETCH;
                end else if (w_timeout) begin
                    w_state_next = ST_FAULT;
                end
            end
            ST_BRANCH: begin
                w_alu_src_a     = 1'b1;
                w_alu_op        = ALUOP_SUB;
                w_pc_write_cond = 1'b1;
                w_pc_source     = PCSRC_ALUOUT;
                w_retire        = 1'b1;
                w_state_next    = ST_FETCH;
            end
            ST_JUMP: begin
                w_pc_write   = 1'b1;
                w_pc_source  = PCSRC_JUMP;
                w_retire     = 1'b1;
                w_state_next = ST_FETCH;
            end
            ST_FAULT: begin
                w_state_next = ST_FAULT;
            end
            default: begin
                w_state_next = ST_FAULT;
            end
        endcase
    end

    // State register; reset drops every enable at once because outputs decode from IDLE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Memory stall counter: counts consecutive not-ready cycles inside one memory state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait <= 8'd0;
        end else if (w_mem_state && !bus.MemReady && (w_state_next == r_state)) begin
            r_wait <= r_wait + 8'd1;
        end else begin
            r_wait <= 8'd0;
        end
    end

    // Opcode is only looked at in DECODE; keep what later states need from it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_is_store  <= 1'b0;
            r_branch_ne <= 1'b0;
        end else if (r_state == ST_DECODE) begin
            r_is_store  <= (w_class == OPC_STORE);
            r_branch_ne <= bus.Opcode[0];
        end
    end

    // Retired-instruction counter, free-running wrap
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (w_retire) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Sticky fault flag, raised together with entry into FAULT
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fault <= 1'b0;
        end else if (w_state_next == ST_FAULT) begin
            r_fault <= 1'b1;
        end
    end

    assign bus.PCWrite     = w_pc_write;
    assign bus.PCWriteCond = w_pc_write_cond;
    assign bus.IorD        = w_iord;
    assign bus.MemRead     = w_mem_read;
    assign bus.MemWrite    = w_mem_write;
    assign bus.IRWrite     = w_ir_write;
    assign bus.MemtoReg    = w_mem_to_reg;
    assign bus.RegDst      = w_reg_dst;
    assign bus.RegWrite    = w_reg_write;
    assign bus.ALUSrcA     = w_alu_src_a;
    assign bus.ALUSrcB     = w_alu_src_b;
    assign bus.ALUOp       = w_alu_op;
    assign bus.PCSource    = w_pc_source;
    assign bus.BranchNe    = (r_state == ST_BRANCH) ? r_branch_ne : 1'b0;
    assign bus.InstrCount  = r_count;
    assign bus.Fault       = r_fault;

endmodule
